// File: rtl/stnq_pkg.sv
// Shared types and constants for the store narrowing queue.
package stnq_pkg;

  localparam int XLEN    = 64;
  localparam int DADDR_W = 9;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [7:0]      be;
    logic            fit;
    logic            misalign;
  } entry_t;

endpackage

// File: rtl/store_lane_fmt.sv
// Combinational store formatter: effective address, lane-aligned data,
// byte enables, fit and misalignment flags for one STUR request.
module store_lane_fmt
  import stnq_pkg::*;
(
  input  logic [XLEN-1:0]    base,
  input  logic [DADDR_W-1:0] daddr9,
  input  logic [XLEN-1:0]    data,
  input  logic [1:0]         size,
  output entry_t             entry
);

  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] masked;
  logic [2:0]      sh;
  logic [2:0]      align_mask;
  logic [7:0]      be_base;
  logic            fit;

  always_comb begin
    addr       = base + {{(XLEN-DADDR_W){daddr9[DADDR_W-1]}}, daddr9};
    sh         = addr[2:0];
    masked     = '0;
    be_base    = '0;
    fit        = 1'b1;
    align_mask = '0;
    // fit: every bit above the narrowed sign bit must equal that sign bit
    case (size_e'(size))
      SZ_B: begin
        masked     = {56'b0, data[7:0]};
        be_base    = 8'h01;
        fit        = (&data[63:7]) | ~(|data[63:7]);
        align_mask = 3'b000;
      end
      SZ_H: begin
        masked     = {48'b0, data[15:0]};
        be_base    = 8'h03;
        fit        = (&data[63:15]) | ~(|data[63:15]);
        align_mask = 3'b001;
      end
      SZ_W: begin
        masked     = {32'b0, data[31:0]};
        be_base    = 8'h0F;
        fit        = (&data[63:31]) | ~(|data[63:31]);
        align_mask = 3'b011;
      end
      default: begin
        masked     = data;
        be_base    = 8'hFF;
        fit        = 1'b1;
        align_mask = 3'b111;
      end
    endcase
    entry.addr     = addr;
    entry.data     = masked << {sh, 3'b000};
    entry.be       = be_base << sh;
    entry.fit      = fit;
    entry.misalign = |(sh & align_mask);
  end

endmodule

// File: rtl/store_narrow_queue.sv
// Store request FIFO with enqueue-side lane formatting.
// Optional macro STNQ_FULL_ACCEPT_EN: accept a write while full when the head drains.
module store_narrow_queue
  import stnq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_base,
  input  logic [DADDR_W-1:0]  in_daddr9,
  input  logic [XLEN-1:0]     in_data,
  input  logic [1:0]          in_size,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_addr,
  output logic [XLEN-1:0]     out_data,
  output logic [7:0]          out_be,
  output logic                out_fit,
  output logic                out_misalign,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic                empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  entry_t          fmt_entry;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            enq;
  logic            deq;

  store_lane_fmt u_fmt (
    .base   (in_base),
    .daddr9 (in_daddr9),
    .data   (in_data),
    .size   (in_size),
    .entry  (fmt_entry)
  );

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

`ifdef STNQ_FULL_ACCEPT_EN
  // full implies a valid head, so out_ready alone frees the slot this edge
  assign in_ready = !full || out_ready;
`else
  assign in_ready = !full;
`endif

  assign out_valid = !empty;
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

  assign out_addr     = head.addr;
  assign out_data     = head.data;
  assign out_be       = head.be;
  assign out_fit      = head.fit;
  assign out_misalign = head.misalign;

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= fmt_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_queue.sv
// Randomized self-checking bench for store_narrow_queue against a queue model.
module tb_store_narrow_queue;
  import stnq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_base;
  logic [8:0]    in_daddr9;
  logic [63:0]   in_data;
  logic [1:0]    in_size;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_addr;
  logic [63:0]   out_data;
  logic [7:0]    out_be;
  logic          out_fit;
  logic          out_misalign;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int total = 0;
  int bad   = 0;
  entry_t mq[$];

  store_narrow_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_base      (in_base),
    .in_daddr9    (in_daddr9),
    .in_data      (in_data),
    .in_size      (in_size),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .out_be       (out_be),
    .out_fit      (out_fit),
    .out_misalign (out_misalign),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference formatter built from byte counts and signed ranges.
  function automatic entry_t ref_fmt(input logic [63:0] b, input logic [8:0] d9,
                                     input logic [63:0] dat, input logic [1:0] sz);
    entry_t      e;
    longint      off;
    longint      v;
    longint      lim;
    int unsigned nb;
    int unsigned sh;
    e   = '0;
    off = d9[8] ? longint'({55'b0, d9}) - 512 : longint'({55'b0, d9});
    e.addr = b + 64'(off);
    nb  = 32'd1 << sz;
    sh  = 32'(e.addr[2:0]);
    if (nb == 8) e.data = dat;
    else         e.data = dat & ((64'd1 << (8 * nb)) - 64'd1);
    e.data = e.data << (8 * sh);
    for (int i = 0; i < 8; i++)
      if (i >= int'(sh) && i < int'(sh + nb)) e.be[i] = 1'b1;
    v = $signed(dat);
    if (nb == 8) e.fit = 1'b1;
    else begin
      lim   = 64'sd1 <<< (8 * nb - 1);
      e.fit = (v >= -lim) && (v < lim);
    end
    e.misalign = (sh % nb) != 0;
    return e;
  endfunction

  task automatic check_state(input string pfx);
    entry_t e;
    e = '0;
    if (mq.size() > 0) e = mq[0];
    check_eq({pfx, ".count"}, 64'(count), 64'(mq.size()));
    check_eq({pfx, ".empty"}, 64'(empty), 64'(mq.size() == 0));
    check_eq({pfx, ".full"}, 64'(full), 64'(mq.size() == DEPTH));
    check_eq({pfx, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    check_eq({pfx, ".out_addr"}, out_addr, e.addr);
    check_eq({pfx, ".out_data"}, out_data, e.data);
    check_eq({pfx, ".out_be"}, 64'(out_be), 64'(e.be));
    check_eq({pfx, ".out_fit"}, 64'(out_fit), 64'(e.fit));
    check_eq({pfx, ".out_misalign"}, 64'(out_misalign), 64'(e.misalign));
  endtask

  // Called at a falling edge; checks state, drives one cycle, updates the model.
  task automatic step(input logic v, input logic [63:0] b, input logic [8:0] d9,
                      input logic [63:0] dat, input logic [1:0] sz, input logic ordy);
    logic   exp_rdy;
    logic   enq;
    logic   deq;
    entry_t e;
    check_state("state");
    in_valid  = v;
    in_base   = b;
    in_daddr9 = d9;
    in_data   = dat;
    in_size   = sz;
    out_ready = ordy;
    #1;
    exp_rdy = (mq.size() < DEPTH);
`ifdef STNQ_FULL_ACCEPT_EN
    if (ordy) exp_rdy = 1'b1;
`endif
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    enq = v && exp_rdy;
    deq = ordy && (mq.size() > 0);
    e   = ref_fmt(b, d9, dat, sz);
    @(posedge clk);
    #1;
    if (deq) void'(mq.pop_front());
    if (enq) mq.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] rb;
    logic [63:0] rd;
    int unsigned shamt;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_base   = '0;
    in_daddr9 = '0;
    in_data   = '0;
    in_size   = '0;
    out_ready = 1'b0;
    #1;
    check_state("reset");
    check_eq("reset.in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Word store at base-4
    step(1'b1, 64'h1000, 9'h1FC, 64'h11223344AABBCCDD, 2'b10, 1'b0);
    check_eq("w.addr", out_addr, 64'hFFC);
    check_eq("w.data", out_data, 64'hAABBCCDD00000000);
    check_eq("w.be", 64'(out_be), 64'hF0);
    check_eq("w.fit", 64'(out_fit), 64'd0);
    check_eq("w.mis", 64'(out_misalign), 64'd0);
    step(1'b0, '0, '0, '0, 2'b00, 1'b1);

    // Byte store, negative value that fits
    step(1'b1, 64'h2003, 9'h000, 64'hFFFFFFFFFFFFFF80, 2'b00, 1'b0);
    check_eq("b.addr", out_addr, 64'h2003);
    check_eq("b.be", 64'(out_be), 64'h08);
    check_eq("b.data", out_data, 64'h0000000080000000);
    check_eq("b.fit", 64'(out_fit), 64'd1);
    step(1'b0, '0, '0, '0, 2'b00, 1'b1);

    // Misaligned half then misaligned doubleword
    step(1'b1, 64'h2001, 9'h000, 64'h0123456789ABCDEF, 2'b01, 1'b0);
    step(1'b1, 64'h2001, 9'h000, 64'h0123456789ABCDEF, 2'b11, 1'b0);
    check_eq("h.be", 64'(out_be), 64'h06);
    check_eq("h.mis", 64'(out_misalign), 64'd1);
    step(1'b0, '0, '0, '0, 2'b00, 1'b1);
    check_eq("x.be", 64'(out_be), 64'hFE);
    check_eq("x.mis", 64'(out_misalign), 64'd1);
    step(1'b0, '0, '0, '0, 2'b00, 1'b1);

    // Fill, then enqueue and dequeue together while full
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 64'h3000 + 64'(i * 8), 9'h000, 64'(i + 1), 2'b11, 1'b0);
    check_eq("fill.full", 64'(full), 64'd1);
    check_eq("fill.in_ready", 64'(in_ready), 64'd0);
    check_eq("fill.count", 64'(count), 64'(DEPTH));
    step(1'b1, 64'h5000, 9'h000, 64'hDEAD, 2'b11, 1'b1);
`ifdef STNQ_FULL_ACCEPT_EN
    check_eq("fullacc.count", 64'(count), 64'(DEPTH));
`else
    check_eq("fullacc.count", 64'(count), 64'(DEPTH - 1));
`endif
    repeat (DEPTH + 1) step(1'b0, '0, '0, '0, 2'b00, 1'b1);
    check_eq("drain.empty", 64'(empty), 64'd1);

    // Asynchronous reset mid-cycle with two entries queued
    step(1'b1, 64'h4000, 9'h010, 64'h55, 2'b00, 1'b0);
    step(1'b1, 64'h4008, 9'h1F0, 64'h66, 2'b01, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_eq("areset.out_valid", 64'(out_valid), 64'd0);
    check_eq("areset.count", 64'(count), 64'd0);
    check_eq("areset.out_addr", out_addr, 64'd0);
    mq.delete();
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 64'h7000, 9'h004, 64'h1234, 2'b01, 1'b0);
    check_eq("post_reset.addr", out_addr, 64'h7004);
    step(1'b0, '0, '0, '0, 2'b00, 1'b1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = 64'hFFFFFFFFFFFFFFF0 | 64'($urandom_range(0, 15));
      rd = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        shamt = 64 - (32'd8 << $urandom_range(0, 3));
        rd = 64'($signed(rd << shamt) >>> shamt);
      end
      step(1'($urandom_range(0, 1)), rb, 9'($urandom), rd, 2'($urandom),
           1'($urandom_range(0, 2) != 0));
    end
    repeat (DEPTH + 1) step(1'b0, '0, '0, '0, 2'b00, 1'b1);
    check_state("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_narrow_queue.md
Name: store_narrow_queue

Overview:
- Store-side counterpart of the Imm9/DAddr9 load-path sign extension.
- Accepts a 64-bit register value, a 64-bit base and a signed 9-bit DAddr9 offset, and forms address = base + sign-extended offset.
- Narrows the value to the STUR size (B/H/W/X) and lane-aligns it into a 64-bit memory word with byte enables.
- Buffers requests in a small FIFO toward the data memory port using valid/ready handshakes on both sides.

Parameters:
DEPTH, 4, number of queue entries (power of 2, >=2)
CW, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous reset, active-low (asserted at 0)
in_valid  input  1  store request valid
in_ready  output  1  queue can accept this cycle
in_base  input  64  base register value
in_daddr9  input  9  signed DAddr9 offset
in_data  input  64  register value to store
in_size  input  2  00=B, 01=H, 10=W, 11=X
out_valid  output  1  head entry valid
out_ready  input  1  memory accepts head
out_addr  output  64  effective address of head
out_data  output  64  lane-aligned store data
out_be  output  8  byte enables
out_fit  output  1  narrowed value sign-extends back to in_data
out_misalign  output  1  address not a multiple of the size
count  output  CW  occupancy
full  output  1  count==DEPTH
empty  output  1  count==0

Behaviour:
- Reset (reset=0, asynchronous):
  - pointers and count cleared.
  - out_valid=0, full=0, empty=1, count=0, in_ready=1.
  - out_addr/out_data/out_be/out_fit/out_misalign=0.
  - Any entries present when reset is asserted mid-operation are discarded.
- Enqueue occurs when in_valid && in_ready at the rising edge. All formatting is computed combinationally at enqueue and stored in the entry:
  - addr = in_base + {{55{in_daddr9[8]}}, in_daddr9}, modulo 2^64.
  - N = 8<<in_size bits.
  - sh = addr[2:0].
  - data = (in_data & mask(N)) << (8*sh), truncated to 64 bits.
  - be = ((1<<(N/8))-1) << sh, truncated to 8 bits.
  - fit = 1 iff in_data[63:N-1] is all-0 or all-1. fit is always 1 for X.
  - misalign = 1 iff sh mod (N/8) != 0.
  - A misaligned entry is still queued and emitted with truncated be; no split. Downstream handles the fault.
- Dequeue occurs when out_valid && out_ready. The head advances on that edge.
- Outputs come straight from the head entry registers. out_valid = !empty. Head outputs are 0 when empty.
- Latency: an entry enqueued at edge k is visible on out_* after edge k (1 cycle). There is no combinational in-to-out path.
- in_ready = !full (base build).
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. When empty, a simultaneous enqueue with no valid head is just an enqueue.
- Pointers wrap modulo DEPTH.
- count increments on enqueue only, decrements on dequeue only.
- Holding rule: out_* must stay stable while out_valid && !out_ready.

Optional Feature:
- Macro STNQ_FULL_ACCEPT_EN.
- Defined: in_ready = !full || out_ready. A write while full is allowed in the same cycle as a dequeue; the tail overwrites the freed slot, count stays DEPTH.
- Undefined: in_ready = !full strictly. A full queue stalls the producer one cycle even when draining.

Decomposition:
- Package stnq_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_X).
  - entry struct {addr, data, be, fit, misalign}.
  - constants DADDR_W=9, XLEN=64.
- Sub-module store_lane_fmt: purely combinational addr/data/be/fit/misalign formatter, instantiated once at the enqueue side.
- store_narrow_queue holds only the FIFO, pointers and handshake.

Test Plan:
- Reset, then base=0x1000, daddr9=9'h1FC (-4), data=0x11223344AABBCCDD, size=W -> next cycle out_addr=0xFFC, out_data=0xAABBCCDD00000000, out_be=0xF0, out_fit=0, out_misalign=0.
- base=0x2003, daddr9=0, data=0xFFFFFFFFFFFFFF80, size=B -> out_addr=0x2003, out_be=0x08, out_data=0x0000000080000000, out_fit=1.
- base=0x2001, daddr9=0, size=H -> out_be=0x06, out_misalign=1. Same address with size=X -> be=0xFE, misalign=1.
- Enqueue 4 with out_ready=0 -> full=1, in_ready=0, count=4. Drain with out_ready=1 -> FIFO order preserved, empty=1 after 4 cycles.
- Full queue, in_valid=1 and out_ready=1 in the same cycle:
  - Macro undefined -> no enqueue, count=3.
  - Macro defined -> enqueue accepted, count=4, new data reaches the head after the other 3.
- Two entries queued, assert reset=0 asynchronously mid-cycle -> out_valid=0, count=0 immediately. After release, a new enqueue appears at the head one cycle later.
